// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//
// Round-robin arbiter and sequencer for the shared 4-source tri-state bus
// (2-to-4 decoder feeding four bufif1 drivers onto a wired net). It grants one
// requester at a time, drives the decoder select/enable, and inserts
// TURN_CYCLES dead cycles between owners so two drivers are never enabled in
// the same cycle.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, an owner holding the bus for MAX_HOLD consecutive cycles is
//   forced off (one-cycle timeout pulse) and becomes lowest priority.
//   When undefined, an owner keeps the bus for as long as it requests it and
//   timeout is tied low.
//
// Parameters:
//   TURN_CYCLES  dead cycles between consecutive owners (1..15)
//   MAX_HOLD     maximum consecutive grant cycles (2..255), timeout build only
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   req[3:0] per-source request, held while the source wants/uses the bus
//   grant    registered one-hot grant, 0000 when nobody owns the bus
//   sel      index of current/last owner -> decoder a,b (sel[1]=a, sel[0]=b)
//   bus_en   |grant, gates decoder outputs onto the bufif1 enables
//   busy     high while in GRANT or TURN
//   timeout  one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned MAX_HOLD    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       bus_en,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  // The counter is loaded with TURN_CYCLES-1 on release; the TURN cycle in
  // which it reads zero is the last dead cycle.
  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;       // last owner; also the current owner in GRANT
  logic [3:0] turn_cnt_q, turn_cnt_d;
  logic       hold_expired;

  // ---------------------------------------------------------------------------
  // Round-robin search: rotate req so bit 0 corresponds to source last+1,
  // take the lowest set bit, then add the rotation back (mod 4).
  // ---------------------------------------------------------------------------
  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] rot_offset;
  logic [1:0] winner;
  logic       found;

  always_comb begin
    req_dbl    = {req, req};
    req_rot    = 4'(req_dbl >> ({1'b0, last_q} + 3'd1));
    found      = |req_rot;
    rot_offset = 2'd0;
    if (req_rot[0])      rot_offset = 2'd0;
    else if (req_rot[1]) rot_offset = 2'd1;
    else if (req_rot[2]) rot_offset = 2'd2;
    else if (req_rot[3]) rot_offset = 2'd3;
    winner = last_q + 2'd1 + rot_offset;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sel_d      = sel_q;
    last_d     = last_q;
    turn_cnt_d = turn_cnt_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = 4'b0001 << winner;
          sel_d   = winner;
          last_d  = winner;
          state_d = GRANT;
        end
      end

      GRANT: begin
        // Other requests are ignored while the owner holds the bus. A drop of
        // the owner's request for even one sampled edge counts as a release.
        if (!req[last_q] || hold_expired) begin
          grant_d    = 4'b0000;
          turn_cnt_d = TURN_LOAD;
          state_d    = TURN;
        end
      end

      TURN: begin
        if (turn_cnt_q == 4'd0) begin
          // Arbitrate straight out of the gap so the dead time is exact.
          if (found) begin
            grant_d = 4'b0001 << winner;
            sel_d   = winner;
            last_d  = winner;
            state_d = GRANT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          turn_cnt_d = turn_cnt_q - 4'd1;
        end
      end

      default: begin
        grant_d = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Last owner resets to 3 so source 0 wins first.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 4'b0000;
      sel_q      <= 2'd0;
      last_q     <= 2'd3;
      turn_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Hold counter: zero on the first grant cycle, so after the k-th grant cycle
  // it reads k-1. Expiry therefore fires at the edge ending cycle MAX_HOLD.
  // ---------------------------------------------------------------------------
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;

  assign hold_expired = (state_q == GRANT) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    hold_cnt_d = 8'd0;
    if (state_q == GRANT) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
    // Only a release with the request still high is a forced one.
    timeout_d = hold_expired && req[last_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // MAX_HOLD only matters in the timeout build.
  localparam int unsigned max_hold_unused = MAX_HOLD;

  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registers, so they move only on edges or reset.
  // ---------------------------------------------------------------------------
  assign grant  = grant_q;
  assign sel    = sel_q;
  assign bus_en = |grant_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
//
// Bench for bus_arbiter_rr. A behavioural model (owner / gap / hold counts and
// a modular round-robin search) is compared with the DUT on every falling
// edge; directed sequences add hand-computed literal expectations, followed by
// a randomized request phase with occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

  localparam int TC = 1;  // turnaround cycles
  localparam int MH = 4;  // max hold (timeout build)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b1111;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       bus_en;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  bit done   = 1'b0;

  bus_arbiter_rr #(
    .TURN_CYCLES(TC),
    .MAX_HOLD   (MH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .grant  (grant),
    .sel    (sel),
    .bus_en (bus_en),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_owner  = -1;  // -1: nobody owns the bus
  int m_last   = 3;
  int m_sel    = 0;
  int m_held   = 0;   // grant cycles completed by current owner
  int m_gap    = 0;   // dead cycles elapsed since release
  bit m_in_gap = 0;
  bit m_to     = 0;

  function automatic int pick(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  initial begin
    int  w;
    bit  may_grant;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_owner = -1; m_last = 3; m_sel = 0; m_held = 0;
        m_gap = 0; m_in_gap = 0; m_to = 0;
      end else begin
        m_to = 0;
        if (m_owner >= 0) begin
          m_held++;
          if (!req[m_owner]) begin
            m_owner = -1; m_in_gap = 1; m_gap = 0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (m_held == MH) begin
            m_owner = -1; m_in_gap = 1; m_gap = 0; m_to = 1;
          end
`endif
        end else begin
          may_grant = 1;
          if (m_in_gap) begin
            m_gap++;
            if (m_gap == TC) m_in_gap = 0;
            else may_grant = 0;
          end
          if (may_grant) begin
            w = pick(m_last, req);
            if (w >= 0) begin
              m_owner = w; m_last = w; m_sel = w; m_held = 0;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // ---------------------------------------------------------------------------
  initial begin
    logic [3:0] exp_grant;
    forever begin
      @(negedge clk);
      if (!done) begin
        cycle++;
        exp_grant = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check("grant",   {4'd0, grant},   {4'd0, exp_grant});
        check("sel",     {6'd0, sel},     8'(m_sel));
        check("bus_en",  {7'd0, bus_en},  {7'd0, (m_owner >= 0)});
        check("busy",    {7'd0, busy},    {7'd0, (m_owner >= 0) || m_in_gap});
        check("timeout", {7'd0, timeout}, {7'd0, m_to});
        if (m_owner >= 0 && m_held == 0)
          $display("cycle %0d: req=%b grant=%b sel=%0d", cycle, req, grant, sel);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};

    // Reset with all requests high
    #2;
    check("rst_grant",  {4'd0, grant}, 8'h00);
    check("rst_sel",    {6'd0, sel},   8'h00);
    check("rst_bus_en", {7'd0, bus_en}, 8'h00);
    check("rst_busy",   {7'd0, busy},  8'h00);
    check("rst_to",     {7'd0, timeout}, 8'h00);
    step(); step();
    check("rst_hold_grant", {4'd0, grant}, 8'h00);
    rst = 1'b0;
    step();
    check("first_grant", {4'd0, grant}, 8'h01);

    // Rotation: each owner drops after 3 cycles, then re-raises
    for (int i = 0; i < 5; i++) begin
      check("rot_grant", {4'd0, grant}, 8'(4'b0001 << seq[i]));
      if (i == 4) break;
      step(); step();
      req[seq[i]] = 1'b0;
      step();
      check("rot_gap", {4'd0, grant}, 8'h00);
      req[seq[i]] = 1'b1;
      step();
    end
    req = 4'b0000;
    step(); step();
    check("rot_idle_busy", {7'd0, busy}, 8'h00);

    // Single request for five cycles
    req = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      step();
      check("single_grant", {4'd0, grant}, 8'h04);
      check("single_sel",   {6'd0, sel},   8'h02);
      check("single_en",    {7'd0, bus_en}, 8'h01);
    end
    req = 4'b0000;
    step();
    check("single_rel", {4'd0, grant}, 8'h00);
    check("single_turn_busy", {7'd0, busy}, 8'h01);
    step();
    check("single_idle_busy", {7'd0, busy}, 8'h00);
    check("single_sel_keep", {6'd0, sel}, 8'h02);

    // Priority wrap
    req = 4'b0010; step();
    check("wrap_g1", {4'd0, grant}, 8'h02);
    req = 4'b0000; step(); step();
    req = 4'b1010; step();
    check("wrap_g3", {4'd0, grant}, 8'h08);
    check("wrap_sel3", {6'd0, sel}, 8'h03);
    req = 4'b0000; step(); step();
    req = 4'b1010; step();
    check("wrap_g1b", {4'd0, grant}, 8'h02);
    req = 4'b0000; step(); step();

    // Asynchronous reset mid-grant
    req = 4'b0100; step();
    check("ar_grant", {4'd0, grant}, 8'h04);
    #2 rst = 1'b1;
    #1;
    check("ar_grant0", {4'd0, grant}, 8'h00);
    check("ar_en0",    {7'd0, bus_en}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    req = 4'b0101;
    step();
    check("ar_after", {4'd0, grant}, 8'h01);
    req = 4'b0000; step(); step();

    // Hold behaviour with req=0011 from a fresh reset
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    req = 4'b0011;
    step();
    check("hold_first", {4'd0, grant}, 8'h01);
`ifdef ARB_TIMEOUT_EN
    for (int c = 1; c < MH; c++) begin
      step();
      check("hold_grant", {4'd0, grant}, 8'h01);
    end
    step();
    check("to_grant0", {4'd0, grant}, 8'h00);
    check("to_pulse",  {7'd0, timeout}, 8'h01);
    for (int c = 1; c < TC; c++) begin
      step();
      check("to_gap", {4'd0, grant}, 8'h00);
      check("to_pulse_end", {7'd0, timeout}, 8'h00);
    end
    step();
    check("to_next", {4'd0, grant}, 8'h02);
    check("to_clear", {7'd0, timeout}, 8'h00);
`else
    for (int c = 0; c < 20; c++) begin
      step();
      check("hold_grant", {4'd0, grant}, 8'h01);
      check("hold_no_to", {7'd0, timeout}, 8'h00);
    end
`endif
    req = 4'b0000; step(); step(); step();

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 4) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step();
    end

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter and sequencer for the shared 4-source tri-state bus.
- That bus is built from a 2-to-4 decoder feeding four bufif1 drivers onto a wired net.
- Grants one of four requesters, drives the decoder select and enable, and inserts turnaround cycles between owners so two bus drivers are never enabled in the same cycle.
- Sits between the requesting blocks and the decoder/tri-state bus instance.

Parameters:
- TURN_CYCLES, 1: dead cycles (grant=0) between consecutive owners; legal range 1..15.
- MAX_HOLD, 16: maximum consecutive grant cycles per owner; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per source; held high while the source wants or uses the bus.
- grant  output  4  one-hot grant, registered; 0000 when no owner.
- sel  output  2  binary index of the current or last owner; connects to the decoder a,b inputs (sel[1]=a, sel[0]=b).
- bus_en  output  1  =|grant; gates the decoder outputs to the bufif1 enables.
- busy  output  1  high in GRANT and TURN states.
- timeout  output  1  one-cycle pulse on forced release; tied 0 when the macro is absent.

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - grant=0000, sel=00, bus_en=0, busy=0, timeout=0.
  - state=IDLE, last-owner pointer=3 (so source 0 has top priority first), counters cleared.
- States: IDLE, GRANT, TURN.
- Arbitration function:
  - Search req starting at (last+1) mod 4, ascending with wrap.
  - The first set bit wins; last is updated to the winner when the grant is issued.
- IDLE:
  - At an edge where req!=0: grant=onehot(winner), sel=winner, go GRANT.
  - Latency: req high before edge N gives grant visible after edge N.
  - Otherwise stay IDLE; sel retains its previous value.
- GRANT:
  - Grant held while req[owner]=1; requests from other sources are ignored.
  - At an edge where req[owner]=0: grant=0000, load the turnaround counter with TURN_CYCLES-1, go TURN.
- TURN:
  - grant=0000, bus_en=0, busy=1.
  - Counter decrements each edge.
  - At the edge where counter=0: if req!=0, arbitrate and go GRANT directly; else go IDLE.
  - Net gap between owners is exactly TURN_CYCLES cycles.
- The previous owner re-requesting during TURN is arbitrated normally. Because it is the last owner, it is lowest priority.
- A source dropping and re-raising req within GRANT is treated as a release.
- grant is never multi-hot. grant and bus_en change only on clock edges or reset.
- Reset asserted mid-GRANT or mid-TURN drops grant immediately. After reset release, source 0 wins the first arbitration.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter is cleared when a grant is issued and increments each GRANT cycle.
  - When an owner has held the grant for MAX_HOLD cycles with req still high: grant=0000 at that edge, timeout=1 for exactly one cycle, go TURN.
  - The owner becomes last (lowest priority). If it is the only requester, it is re-granted after the turnaround.
- Not defined: no hold counter; timeout constant 0; grant persists while req[owner]=1.

Test Plan:
- Reset: rst=1 with req=1111 -> grant=0000, sel=00, bus_en=0, busy=0, timeout=0. Release rst with req=1111 -> grant=0001 after the first edge.
- Single request: req=0100 for 5 cycles, then 0000 -> grant=0100, sel=10, bus_en=1 for exactly 5 cycles. grant=0000 at the edge req is sampled low. Returns to IDLE after 1 TURN cycle.
- Rotation (TURN_CYCLES=1): req=1111, each owner drops its bit after 3 granted cycles, then re-raises it -> grants 0001, 0010, 0100, 1000, 0001, with exactly one grant=0000 cycle between each.
- Priority wrap: last owner=1, next req=1010 -> grant=1000, sel=11. Then with last=3 and req=1010 -> grant=0010.
- Async reset mid-grant: grant=0100 and rst pulsed between clock edges -> grant=0000, bus_en=0 immediately. After release with req=0101 -> grant=0001.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4, TURN_CYCLES=2): req=0011 held -> grant=0001 for 4 cycles, timeout=1 for one cycle, 2 dead cycles, then grant=0010. Without the macro, grant=0001 persists and timeout stays 0.
